// File: rtl/game_pkg.sv
// Shared encodings for the fighter datapath: hit-detector flag codes,
// player FSM state codes and the stun status encoding.
package game_pkg;

    typedef enum logic [1:0] {
        NOT_HIT   = 2'b00,
        HIT_BASIC = 2'b01,
        HIT_DIR   = 2'b10
    } hit_t;

    // Only the codes this block requests; the player FSM owns the full set.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HITSTUN   = 4'd9,
        S_BLOCKSTUN = 4'd10
    } player_state_t;

    typedef enum logic [1:0] {
        STUN_NONE  = 2'b00,
        STUN_HIT   = 2'b01,
        STUN_BLOCK = 2'b10,
        STUN_KO    = 2'b11
    } stun_t;

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter advanced by frame_tick; expire pulses combinationally
// on the tick that takes the count from 1 to 0.
module frame_countdown #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // A load in the same cycle wins over the tick, so no expiry then.
    assign expire = tick && !load && !clear && (count == CNT_W'(1));

endmodule

// File: rtl/hit_response.sv
// Per-player hit consumer: one-shot hit events, damage, hitstun/blockstun timing.
// Define CHIP_DAMAGE_EN to make blocked basic hits cost 1 health.
module hit_response
    import game_pkg::*;
#(
    parameter int unsigned HEALTH_MAX       = 100,
    parameter int unsigned BASIC_DMG        = 5,
    parameter int unsigned DIR_DMG          = 10,
    parameter int unsigned HITSTUN_FRAMES   = 20,
    parameter int unsigned BLOCKSTUN_FRAMES = 12,
    parameter int unsigned CNT_W            = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       round_restart,
    input  logic [1:0] hit_flag,
    input  logic       blocking,
    output logic [6:0] health,
    output logic [1:0] stun,
    output logic [3:0] stun_state,
    output logic       hit_ack,
    output logic       knocked_out
);

    typedef enum logic [1:0] {
        R_READY,
        R_HITSTUN,
        R_BLOCKSTUN,
        R_KO
    } rsp_state_t;

    localparam logic [6:0] HEALTH_FULL = 7'(HEALTH_MAX);
    localparam logic [6:0] BASIC_D     = 7'(BASIC_DMG);
    localparam logic [6:0] DIR_D       = 7'(DIR_DMG);
`ifdef CHIP_DAMAGE_EN
    localparam logic [6:0] CHIP_D      = 7'd1;
`else
    localparam logic [6:0] CHIP_D      = 7'd0;
`endif

    rsp_state_t       state, state_nxt;
    logic [6:0]       health_nxt;
    logic             armed, armed_nxt;
    logic             ko_nxt;
    logic             flag_valid, blocked, accept, ko_hit;
    logic [6:0]       dmg, dmg_health;
    logic             cnt_load, cnt_tick, cnt_expire;
    logic [CNT_W-1:0] cnt_val;

    frame_countdown #(.CNT_W(CNT_W)) u_stun_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (round_restart),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (cnt_tick),
        .expire   (cnt_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= R_READY;
            health      <= HEALTH_FULL;
            armed       <= 1'b1;
            hit_ack     <= 1'b0;
            knocked_out <= 1'b0;
        end else begin
            state       <= state_nxt;
            health      <= health_nxt;
            armed       <= armed_nxt;
            hit_ack     <= accept;
            knocked_out <= ko_nxt;
        end
    end

    always_comb begin
        flag_valid = (hit_flag == HIT_BASIC) || (hit_flag == HIT_DIR);
        blocked    = (hit_flag == HIT_BASIC) && blocking;
        accept     = flag_valid && armed && (state == R_READY) && !round_restart;

        if (hit_flag == HIT_DIR) dmg = DIR_D;
        else if (blocked)        dmg = CHIP_D;
        else                     dmg = BASIC_D;

        // Compare before subtracting so the health never wraps below zero.
        dmg_health = (health > dmg) ? (health - dmg) : '0;
        ko_hit     = accept && (dmg_health == '0);

        state_nxt  = state;
        health_nxt = health;
        ko_nxt     = knocked_out;
        armed_nxt  = !flag_valid;
        cnt_load   = 1'b0;
        cnt_val    = blocked ? CNT_W'(BLOCKSTUN_FRAMES) : CNT_W'(HITSTUN_FRAMES);
        cnt_tick   = frame_tick && (state == R_HITSTUN || state == R_BLOCKSTUN);

        if (round_restart) begin
            state_nxt  = R_READY;
            health_nxt = HEALTH_FULL;
            ko_nxt     = 1'b0;
            armed_nxt  = 1'b0;
        end else if (accept) begin
            health_nxt = dmg_health;
            if (ko_hit) begin
                state_nxt = R_KO;
                ko_nxt    = 1'b1;
            end else begin
                state_nxt = blocked ? R_BLOCKSTUN : R_HITSTUN;
                cnt_load  = 1'b1;
            end
        end else if (cnt_expire) begin
            state_nxt = R_READY;
        end
    end

    always_comb begin
        stun       = STUN_NONE;
        stun_state = S_IDLE;
        case (state)
            R_HITSTUN:   begin stun = STUN_HIT;   stun_state = S_HITSTUN;   end
            R_BLOCKSTUN: begin stun = STUN_BLOCK; stun_state = S_BLOCKSTUN; end
            R_KO:        begin stun = STUN_KO;    stun_state = S_HITSTUN;   end
            default:     begin stun = STUN_NONE;  stun_state = S_IDLE;      end
        endcase
    end

endmodule

// File: tb/tb_hit_response.sv
// Directed bench for hit_response: one-shot events, damage, stun timing, KO, restart.
module tb_hit_response;

`ifdef CHIP_DAMAGE_EN
    localparam int CHIP = 1;
`else
    localparam int CHIP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       round_restart = 1'b0;
    logic [1:0] hit_flag = 2'b00;
    logic       blocking = 1'b0;
    logic [6:0] health;
    logic [1:0] stun;
    logic [3:0] stun_state;
    logic       hit_ack;
    logic       knocked_out;

    int errors = 0;
    int checks = 0;
    int acks;
    int exp_h;

    hit_response dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .round_restart (round_restart),
        .hit_flag      (hit_flag),
        .blocking      (blocking),
        .health        (health),
        .stun          (stun),
        .stun_state    (stun_state),
        .hit_ack       (hit_ack),
        .knocked_out   (knocked_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic pulse_hit(input logic [1:0] f, input logic b);
        hit_flag = f;
        blocking = b;
        cyc(1);
        hit_flag = 2'b00;
        blocking = 1'b0;
        cyc(1);
    endtask

    initial begin
        // Reset values
        cyc(2);
        rst_n = 1'b1;
        check("rst_health", health, 100);
        check("rst_stun", stun, 0);
        check("rst_state", stun_state, 0);
        check("rst_ack", hit_ack, 0);
        check("rst_ko", knocked_out, 0);

        // Basic hit held 5 cycles: exactly one event
        acks = 0;
        hit_flag = 2'b01;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            acks += int'(hit_ack);
        end
        hit_flag = 2'b00;
        exp_h = 95;
        check("held_acks", acks, 1);
        check("basic_health", health, exp_h);
        check("basic_stun", stun, 1);
        check("basic_state", stun_state, 9);
        ticks(19);
        check("hitstun_19", stun, 1);
        ticks(1);
        check("hitstun_20", stun, 0);
        check("hitstun_20_state", stun_state, 0);

        // Blocked basic hit
        hit_flag = 2'b01;
        blocking = 1'b1;
        cyc(1);
        check("block_ack", hit_ack, 1);
        hit_flag = 2'b00;
        blocking = 1'b0;
        cyc(1);
        exp_h = exp_h - CHIP;
        check("block_health", health, exp_h);
        check("block_stun", stun, 2);
        check("block_state", stun_state, 10);
        ticks(11);
        check("blockstun_11", stun, 2);
        ticks(1);
        check("blockstun_12", stun, 0);

        // Directional is unblockable
        pulse_hit(2'b10, 1'b1);
        exp_h = exp_h - 10;
        check("dir_health", health, exp_h);
        check("dir_stun", stun, 1);

        // Hit mid-hitstun ignored; flag held across expiry stays dead
        ticks(5);
        acks = 0;
        hit_flag = 2'b10;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            acks += int'(hit_ack);
        end
        check("midstun_acks", acks, 0);
        check("midstun_health", health, exp_h);
        ticks(15);
        cyc(3);
        check("held_expiry_stun", stun, 0);
        check("held_expiry_health", health, exp_h);
        check("held_expiry_ack", hit_ack, 0);
        hit_flag = 2'b00;
        cyc(1);
        hit_flag = 2'b10;
        cyc(1);
        check("rearm_ack", hit_ack, 1);
        hit_flag = 2'b00;
        cyc(1);
        exp_h = exp_h - 10;
        check("rearm_health", health, exp_h);
        ticks(20);
        check("rearm_expire", stun, 0);

        // Hit coincident with frame_tick: full 20 ticks
        hit_flag = 2'b01;
        frame_tick = 1'b1;
        cyc(1);
        hit_flag = 2'b00;
        frame_tick = 1'b0;
        cyc(1);
        exp_h = exp_h - 5;
        check("coinc_health", health, exp_h);
        ticks(19);
        check("coinc_19", stun, 1);
        ticks(1);
        check("coinc_20", stun, 0);

        // Reset mid-stun
        pulse_hit(2'b01, 1'b0);
        ticks(3);
        rst_n = 1'b0;
        cyc(1);
        check("midrst_health", health, 100);
        check("midrst_stun", stun, 0);
        check("midrst_state", stun_state, 0);
        check("midrst_ack", hit_ack, 0);
        rst_n = 1'b1;
        cyc(1);

        // Drain to 10 with directionals, basic to 5, then saturating KO
        for (int i = 0; i < 9; i++) begin
            pulse_hit(2'b10, 1'b0);
            ticks(20);
        end
        check("drain_health", health, 10);
        pulse_hit(2'b01, 1'b0);
        check("h5_health", health, 5);
        ticks(20);
        hit_flag = 2'b10;
        cyc(1);
        check("ko_ack", hit_ack, 1);
        hit_flag = 2'b00;
        cyc(1);
        check("ko_health", health, 0);
        check("ko_flag", knocked_out, 1);
        check("ko_stun", stun, 3);
        check("ko_state", stun_state, 9);

        // Hits during KO ignored; KO survives ticks
        acks = 0;
        hit_flag = 2'b01;
        cyc(1);
        acks += int'(hit_ack);
        hit_flag = 2'b00;
        cyc(1);
        acks += int'(hit_ack);
        hit_flag = 2'b10;
        cyc(1);
        acks += int'(hit_ack);
        hit_flag = 2'b00;
        check("ko_ignore_acks", acks, 0);
        ticks(25);
        check("ko_sticky_stun", stun, 3);
        check("ko_sticky_health", health, 0);

        // round_restart beats a coincident hit, then needs the flag to drop
        hit_flag = 2'b01;
        round_restart = 1'b1;
        cyc(1);
        round_restart = 1'b0;
        check("restart_health", health, 100);
        check("restart_stun", stun, 0);
        check("restart_ko", knocked_out, 0);
        check("restart_ack", hit_ack, 0);
        cyc(1);
        check("restart_unarmed_ack", hit_ack, 0);
        check("restart_unarmed_health", health, 100);
        hit_flag = 2'b00;
        cyc(1);
        hit_flag = 2'b01;
        cyc(1);
        check("post_restart_ack", hit_ack, 1);
        check("post_restart_health", health, 95);
        hit_flag = 2'b00;
        cyc(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
